// File: rtl/mioc_gate_test_seq.sv
// Pattern sequencer for single-gate test structures: it walks all 2^N_IN input
// patterns, lets each one settle, checks the synchronized output and streams one record per pattern.
module mioc_gate_test_seq #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int ERR_W         = N_IN + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_z,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [(1<<N_IN)-1:0]   fail_mask,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N_IN-1:0]        res_pat,
    output logic                   res_z,
    output logic                   res_exp
);
    localparam int NPAT  = 1 << N_IN;
    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_REPORT, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [N_IN-1:0]  r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sync;
    logic             w_z_s, w_last, w_hs, w_mismatch;

    assign w_z_s      = r_sync[1];
    assign w_last     = (r_pat == N_IN'(NPAT - 1));
    assign w_hs       = res_valid && res_ready;
    assign w_mismatch = (w_z_s != expected[r_pat]);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    // dut_z is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], dut_z};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_DRIVE;
                S_DRIVE:  w_next = S_SETTLE;
                S_SETTLE: if (r_cnt == '0) w_next = S_SAMPLE;
                S_SAMPLE: w_next = S_REPORT;
                S_REPORT: if (w_hs) w_next = w_last ? S_DONE : S_DRIVE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_in    <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
            res_valid <= 1'b0;
            res_pat   <= '0;
            res_z     <= 1'b0;
            res_exp   <= 1'b0;
            r_pat     <= '0;
            r_cnt     <= '0;
        end else if (abort) begin
            // Partial err_count/fail_mask are kept for post-mortem.
            dut_in    <= '0;
            res_valid <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    err_count <= '0;
                    fail_mask <= '0;
                    pass      <= 1'b0;
                    r_pat     <= '0;
                end
                S_DRIVE: begin
                    dut_in <= r_pat;
                    r_cnt  <= CNT_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                S_SAMPLE: begin
                    res_z     <= w_z_s;
                    res_exp   <= expected[r_pat];
                    res_pat   <= r_pat;
                    res_valid <= 1'b1;
                    if (w_mismatch) begin
                        err_count        <= err_count + 1'b1;
                        fail_mask[r_pat] <= 1'b1;
                    end
                end
                S_REPORT: if (w_hs) begin
                    res_valid <= 1'b0;
                    if (!w_last) r_pat <= r_pat + 1'b1;
                end
                S_DONE: pass <= (err_count == '0);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mioc_gate_test_seq.sv
// Randomized scoreboard bench for mioc_gate_test_seq: the gate is a truth-table model,
// the records are predicted from it and from the expected table, and a monitor checks each handshake.
module tb_mioc_gate_test_seq;
    logic       clk = 1'b0;
    logic       rst, start, abort, res_ready;
    logic [3:0] expected;
    logic [1:0] dut_in;
    logic       dut_z;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;
    logic       res_valid;
    logic [1:0] res_pat;
    logic       res_z, res_exp;
    logic [3:0] gate_tt;

    always #5 clk = ~clk;
    assign dut_z = gate_tt[dut_in];

    mioc_gate_test_seq #(.N_IN(2), .SETTLE_CYCLES(8), .ERR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .dut_in(dut_in), .dut_z(dut_z), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask), .res_valid(res_valid),
        .res_ready(res_ready), .res_pat(res_pat), .res_z(res_z), .res_exp(res_exp)
    );

    typedef struct packed { logic [1:0] pat; logic z; logic e; } rec_t;
    rec_t q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a visible valid&&ready at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rec_unexpected: got pat %0d expected no record", res_pat);
            end else begin
                rec_t r;
                r = q.pop_front();
                chk("rec_pat", 32'(res_pat), 32'(r.pat));
                chk("rec_z",   32'(res_z),   32'(r.z));
                chk("rec_exp", 32'(res_exp), 32'(r.e));
            end
        end
    end

    task automatic push_run(input logic [3:0] tt, input logic [3:0] ex);
        rec_t r;
        for (int p = 0; p < 4; p++) begin
            r.pat = 2'(p); r.z = tt[p]; r.e = ex[p];
            q.push_back(r);
        end
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One full run; the latency counts the cycle after the start edge as cycle 1.
    task automatic run(input logic [3:0] tt, input logic [3:0] ex, input bit rnd,
                       input bit stall2, input bit start_mid);
        int cyc = 0, stalls = 0, sc = 0;
        bit got = 0;
        gate_tt = tt; expected = ex;
        push_run(tt, ex);
        pulse_start();
        while (cyc < 1000 && !got) begin
            start = (start_mid && cyc == 20);
            if (stall2 && res_valid && res_pat == 2'd2 && sc < 5) begin
                res_ready = 1'b0;
                chk("stall_valid", 32'(res_valid), 1);
                chk("stall_pat",   32'(res_pat),   2);
                chk("stall_dutin", 32'(dut_in),    2);
                sc++;
            end else if (rnd) res_ready = ($urandom_range(0, 2) != 0);
            else res_ready = 1'b1;
            if (res_valid && !res_ready) stalls++;
            @(posedge clk); #1; cyc++;
            if (done) got = 1;
        end
        start = 1'b0; res_ready = 1'b1;
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end else begin
            chk("done_latency", 32'(cyc + 1), 32'(4 * 11 + 1 + stalls));
            if (stall2) chk("done_latency_stall", 32'(cyc + 1), 50);
        end
        chk("err_count", 32'(err_count), 32'($countones(tt ^ ex)));
        chk("fail_mask", 32'(fail_mask), 32'(tt ^ ex));
        @(posedge clk); #1;
        chk("pass",       32'(pass),   32'((tt ^ ex) == 4'b0));
        chk("done_pulse", 32'(done),   0);
        chk("busy_idle",  32'(busy),   0);
        chk("dutin_hold", 32'(dut_in), 3);
        chk("queue_empty", 32'(q.size()), 0);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        expected = 4'b0; gate_tt = 4'b0;
        #2;
        chk("reset_outs", 32'({dut_in, busy, done, pass, err_count, fail_mask,
                               res_valid, res_pat, res_z, res_exp}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // NOR2, stuck-at-0, stuck-at-1, then NOR2 again to see results cleared.
        run(4'b0001, 4'b0001, 0, 0, 0);
        run(4'b0000, 4'b0001, 0, 0, 0);
        run(4'b1111, 4'b0001, 0, 0, 0);
        run(4'b0001, 4'b0001, 0, 0, 1);
        // Backpressure on pattern 2.
        run(4'b0001, 4'b0001, 0, 1, 0);

        // Abort in SETTLE of pattern 1, with a stray start during the run.
        gate_tt = 4'b0000; expected = 4'b0001;
        push_run(gate_tt, expected);
        pulse_start();
        cyc = 0;
        while (cyc < 100 && dut_in != 2'd1) begin
            start = (cyc == 3);
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        chk("pat1_drive_cycle", 32'(cyc), 12);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        q.delete();
        chk("abort_busy",  32'(busy),   0);
        chk("abort_dutin", 32'(dut_in), 0);
        chk("abort_done",  32'(done),   0);
        chk("abort_pass",  32'(pass),   0);
        chk("abort_err",   32'(err_count), 1);
        chk("abort_mask",  32'(fail_mask), 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("abort_quiet", 32'(seen), 0);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 0);
        @(posedge clk); #1;
        chk("start_abort_idle2", 32'(busy), 0);

        // Async reset while a record waits in REPORT.
        gate_tt = 4'b0001; expected = 4'b0001;
        res_ready = 1'b0;
        pulse_start();
        cyc = 0;
        while (cyc < 100 && !res_valid) begin
            @(posedge clk); #1; cyc++;
        end
        chk("report_reached", 32'(res_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_outs", 32'({dut_in, busy, done, pass, err_count, fail_mask,
                                     res_valid, res_pat, res_z, res_exp}), 0);
        q.delete();
        @(posedge clk); #1 rst = 1'b0; res_ready = 1'b1;
        run(4'b0001, 4'b0001, 0, 0, 0);

        // Random gates, tables and backpressure.
        for (int i = 0; i < 8; i++)
            run(4'($urandom), 4'($urandom), 1, 0, (i % 3) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
